// File: rtl/ofs_plat_test_mmio64_csr.sv
// ofs_plat_test_mmio64_csr
//
// Avalon MMIO CSR responder sitting on the 64-bit MMIO port exported by the
// platform shim. It decodes host reads and writes into a fixed bank of 64-bit
// CSRs and drives control pulses into the AFU's host_mem engine.
//
// Word map (addr[3:0], upper address bits must be zero):
//   0 DFH (RO)        1 AFU_ID[63:0] (RO)     2 AFU_ID[127:64] (RO)
//   3 SCRATCH (RW)    4 CTRL (WO, reads 0)    5 STATUS live/sticky (W1C)
//   6 CYCLES (RO)     7 RD_CNT (RO)           8 WR_CNT (RO)
//   any other word reads 0, writes ignored.
//
// Optional feature macro: OFS_PLAT_TEST_CSR_ACCESS_CNT_EN
//   defined   : RD_CNT / WR_CNT access counters are implemented
//   undefined : no counter flops, words 7 and 8 read 0
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   avs_address/read/write/...  Avalon-MM slave (word addressed, 64-bit)
//   avs_waitrequest             high in reset and for one clk after release
//   avs_readdata/readdatavalid  read response, fixed 2-cycle latency
//   status_live                 live engine status (read-only view)
//   status_err_set              error pulses, latched into sticky bits
//   ctrl_start, ctrl_clear      one-cycle control pulses
//   scratch_out                 current scratch register value

module ofs_plat_test_mmio64_csr #(
  parameter int unsigned    ADDR_WIDTH   = 16,
  parameter logic [63:0]    DFH_VALUE    = 64'h1000_0100_0000_0000,
  parameter logic [127:0]   AFU_ID       = '0,
  parameter int unsigned    STATUS_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [63:0]             avs_writedata,
  input  logic [7:0]              avs_byteenable,
  output logic                    avs_waitrequest,
  output logic [63:0]             avs_readdata,
  output logic                    avs_readdatavalid,
  input  logic [STATUS_WIDTH-1:0] status_live,
  input  logic [STATUS_WIDTH-1:0] status_err_set,
  output logic                    ctrl_start,
  output logic                    ctrl_clear,
  output logic [63:0]             scratch_out
);

  logic                    wait_q;
  logic                    accept_rd;
  logic                    accept_wr;
  logic                    hit;
  logic [3:0]              word;
  logic                    wr_scratch;
  logic                    wr_ctrl;
  logic                    wr_status;

  logic [63:0]             scratch_q;
  logic [STATUS_WIDTH-1:0] sticky_q;
  logic [STATUS_WIDTH-1:0] w1c_mask;
  logic [63:0]             cycles_q;
  logic                    start_q;
  logic                    clear_q;

  logic [63:0]             rd_cnt_word;
  logic [63:0]             wr_cnt_word;
  logic [63:0]             status_word;
  logic [63:0]             rd_mux;

  logic                    rd_v1_q;
  logic [63:0]             rd_d1_q;
  logic                    rd_v2_q;
  logic [63:0]             rd_d2_q;

  // Waitrequest: set by reset, falls on the first clock after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wait_q <= 1'b1;
    else       wait_q <= 1'b0;
  end

  assign avs_waitrequest = wait_q;

  assign accept_rd  = avs_read  & ~wait_q;
  assign accept_wr  = avs_write & ~wait_q;
  assign hit        = (avs_address[ADDR_WIDTH-1:4] == '0);
  assign word       = avs_address[3:0];
  assign wr_scratch = accept_wr & hit & (word == 4'd3);
  assign wr_ctrl    = accept_wr & hit & (word == 4'd4);
  assign wr_status  = accept_wr & hit & (word == 4'd5);

  // Scratch: per-byte write enable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scratch_q <= '0;
    end else if (wr_scratch) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (avs_byteenable[i]) scratch_q[8*i +: 8] <= avs_writedata[8*i +: 8];
      end
    end
  end

  assign scratch_out = scratch_q;

  // Sticky errors: W1C from the upper half of the write data; a set pulse in
  // the same cycle as the clear keeps the bit set.
  assign w1c_mask = wr_status ? avs_writedata[32 +: STATUS_WIDTH] : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sticky_q <= '0;
    else       sticky_q <= (sticky_q & ~w1c_mask) | status_err_set;
  end

  // Control pulses, one clock after the accepting edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_q <= 1'b0;
      clear_q <= 1'b0;
    end else begin
      start_q <= wr_ctrl & avs_writedata[0];
      clear_q <= wr_ctrl & avs_writedata[1];
    end
  end

  assign ctrl_start = start_q;
  assign ctrl_clear = clear_q;

  // Free-running cycle counter; the clear cycle loads 0 instead of counting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        cycles_q <= '0;
    else if (clear_q) cycles_q <= '0;
    else              cycles_q <= cycles_q + 64'd1;
  end

`ifdef OFS_PLAT_TEST_CSR_ACCESS_CNT_EN
  logic [63:0] rd_cnt_q;
  logic [63:0] wr_cnt_q;

  // On the clear pulse the write counter restarts at 1 so that the clearing
  // CTRL write itself stays counted; accesses landing in the clear cycle are
  // dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (clear_q) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= 64'd1;
    end else begin
      if (accept_rd) rd_cnt_q <= rd_cnt_q + 64'd1;
      if (accept_wr) wr_cnt_q <= wr_cnt_q + 64'd1;
    end
  end

  assign rd_cnt_word = rd_cnt_q;
  assign wr_cnt_word = wr_cnt_q;
`else
  assign rd_cnt_word = '0;
  assign wr_cnt_word = '0;
`endif

  always_comb begin
    status_word                        = '0;
    status_word[STATUS_WIDTH-1:0]      = status_live;
    status_word[32 +: STATUS_WIDTH]    = sticky_q;
  end

  always_comb begin
    rd_mux = '0;
    if (hit) begin
      case (word)
        4'd0:    rd_mux = DFH_VALUE;
        4'd1:    rd_mux = AFU_ID[63:0];
        4'd2:    rd_mux = AFU_ID[127:64];
        4'd3:    rd_mux = scratch_q;
        4'd5:    rd_mux = status_word;
        4'd6:    rd_mux = cycles_q;
        4'd7:    rd_mux = rd_cnt_word;
        4'd8:    rd_mux = wr_cnt_word;
        default: rd_mux = '0;
      endcase
    end
  end

  // Read data is captured in the accept cycle so RD_CNT returns its
  // pre-increment value; the second stage only delays. Data is forced to 0
  // in any slot without a valid read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_v1_q <= 1'b0;
      rd_d1_q <= '0;
      rd_v2_q <= 1'b0;
      rd_d2_q <= '0;
    end else begin
      rd_v1_q <= accept_rd;
      rd_d1_q <= accept_rd ? rd_mux : '0;
      rd_v2_q <= rd_v1_q;
      rd_d2_q <= rd_d1_q;
    end
  end

  assign avs_readdatavalid = rd_v2_q;
  assign avs_readdata      = rd_d2_q;

endmodule

// File: tb/tb_ofs_plat_test_mmio64_csr.sv
// Scoreboard bench for ofs_plat_test_mmio64_csr. Reads push expected data and
// the expected response cycle; a negedge monitor pops and compares.
module tb_ofs_plat_test_mmio64_csr;

  localparam logic [63:0]  DFH   = 64'h1000_0100_0000_0000;
  localparam logic [127:0] AFUID = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

`ifdef OFS_PLAT_TEST_CSR_ACCESS_CNT_EN
  localparam logic [63:0] EXP_WR1  = 64'd1;
  localparam logic [63:0] EXP_RD2  = 64'd2;
  localparam logic [63:0] EXP_RD13 = 64'd13;
`else
  localparam logic [63:0] EXP_WR1  = 64'd0;
  localparam logic [63:0] EXP_RD2  = 64'd0;
  localparam logic [63:0] EXP_RD13 = 64'd0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [63:0] avs_writedata;
  logic [7:0]  avs_byteenable;
  logic        avs_waitrequest;
  logic [63:0] avs_readdata;
  logic        avs_readdatavalid;
  logic [31:0] status_live;
  logic [31:0] status_err_set;
  logic        ctrl_start;
  logic        ctrl_clear;
  logic [63:0] scratch_out;

  typedef struct {
    logic [63:0] data;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  ofs_plat_test_mmio64_csr #(
    .ADDR_WIDTH   (16),
    .DFH_VALUE    (DFH),
    .AFU_ID       (AFUID),
    .STATUS_WIDTH (32)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .avs_address       (avs_address),
    .avs_read          (avs_read),
    .avs_write         (avs_write),
    .avs_writedata     (avs_writedata),
    .avs_byteenable    (avs_byteenable),
    .avs_waitrequest   (avs_waitrequest),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .status_live       (status_live),
    .status_err_set    (status_err_set),
    .ctrl_start        (ctrl_start),
    .ctrl_clear        (ctrl_clear),
    .scratch_out       (scratch_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Monitor: compare every response against the scoreboard head.
  always @(negedge clk) begin
    if (avs_readdatavalid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 64'(avs_readdatavalid), 64'd0);
      end else begin
        mon_e = sb.pop_front();
        chk("rd_data", avs_readdata, mon_e.data);
        chk("rd_latency", 64'(cyc), 64'(mon_e.cyc));
      end
    end else begin
      chk("rd_data_idle_zero", avs_readdata, 64'd0);
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
        chk("rd_missing", 64'(avs_readdatavalid), 64'd1);
        mon_e = sb.pop_front();
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    avs_read  = 1'b0;
    avs_write = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [63:0] e);
    avs_read    = 1'b1;
    avs_write   = 1'b0;
    avs_address = a;
    sb.push_back('{data: e, cyc: cyc + 2});
    tick();
  endtask

  task automatic wr(input logic [15:0] a, input logic [63:0] d, input logic [7:0] be);
    avs_read       = 1'b0;
    avs_write      = 1'b1;
    avs_address    = a;
    avs_writedata  = d;
    avs_byteenable = be;
    tick();
  endtask

  initial begin
    reset          = 1'b1;
    avs_address    = '0;
    avs_read       = 1'b0;
    avs_write      = 1'b0;
    avs_writedata  = '0;
    avs_byteenable = '0;
    status_live    = 32'h0000_1234;
    status_err_set = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wait", 64'(avs_waitrequest), 64'd1);
    chk("rst_valid", 64'(avs_readdatavalid), 64'd0);
    chk("rst_start", 64'(ctrl_start), 64'd0);
    chk("rst_clear", 64'(ctrl_clear), 64'd0);
    chk("rst_scratch", scratch_out, 64'd0);

    reset = 1'b0;
    #1;
    chk("wait_after_release", 64'(avs_waitrequest), 64'd1);
    @(posedge clk);
    #1;
    chk("wait_low", 64'(avs_waitrequest), 64'd0);

    // DFH read
    rd(16'd0, DFH);
    idle();
    repeat (3) tick();

    // Scratch byte enables
    wr(16'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
    wr(16'd3, 64'h0, 8'h0F);
    rd(16'd3, 64'hFFFF_FFFF_0000_0000);
    idle();
    chk("scratch_out_1", scratch_out, 64'hFFFF_FFFF_0000_0000);
    wr(16'd3, 64'h1122_3344_5566_7788, 8'b1010_0101);
    idle();
    chk("scratch_out_2", scratch_out, 64'h11FF_33FF_0066_0088);
    tick();

    // Back-to-back reads, including unmapped words and upper address bits
    rd(16'd1, AFUID[63:0]);
    rd(16'd2, AFUID[127:64]);
    rd(16'd3, 64'h11FF_33FF_0066_0088);
    rd(16'd9, 64'h0);
    rd(16'h0013, 64'h0);
    rd(16'h8000, 64'h0);
    rd(16'd4, 64'h0);
    idle();
    repeat (3) tick();

    // Sticky status
    status_err_set = 32'h8;
    tick();
    status_err_set = '0;
    rd(16'd5, 64'h0000_0008_0000_1234);
    idle();
    tick();
    status_err_set = 32'h8;
    wr(16'd5, 64'h0000_0008_0000_0000, 8'h00);
    status_err_set = '0;
    rd(16'd5, 64'h0000_0008_0000_1234);
    wr(16'd5, 64'h0000_0008_0000_0000, 8'h00);
    rd(16'd5, 64'h0000_0000_0000_1234);
    status_live = 32'hDEAD_BEEF;
    rd(16'd5, 64'h0000_0000_DEAD_BEEF);
    idle();
    repeat (3) tick();

    // CTRL pulses, cycle counter clear, access counters
    avs_read       = 1'b0;
    avs_write      = 1'b1;
    avs_address    = 16'd4;
    avs_writedata  = 64'h3;
    avs_byteenable = 8'hFF;
    chk("start_pre", 64'(ctrl_start), 64'd0);
    tick();
    idle();
    chk("start_pulse", 64'(ctrl_start), 64'd1);
    chk("clear_pulse", 64'(ctrl_clear), 64'd1);
    tick();
    chk("start_end", 64'(ctrl_start), 64'd0);
    chk("clear_end", 64'(ctrl_clear), 64'd0);
    repeat (3) tick();
    rd(16'd6, 64'd3);
    rd(16'd8, EXP_WR1);
    rd(16'd7, EXP_RD2);
    for (int i = 0; i < 10; i++) rd(16'd0, DFH);
    rd(16'd7, EXP_RD13);
    idle();
    repeat (3) tick();

    // Reset with two reads in flight
    rd(16'd0, 64'h0);
    rd(16'd1, 64'h0);
    idle();
    reset = 1'b1;
    sb.delete();
    #1;
    chk("inflight_valid_rst", 64'(avs_readdatavalid), 64'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("wait_after_release2", 64'(avs_waitrequest), 64'd1);
    tick();
    chk("wait_low2", 64'(avs_waitrequest), 64'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("no_valid_after_rst", 64'(avs_readdatavalid), 64'd0);
    end
    chk("scratch_after_rst", scratch_out, 64'd0);
    rd(16'd3, 64'h0);
    rd(16'd5, 64'h0000_0000_DEAD_BEEF);
    rd(16'd0, DFH);
    idle();
    repeat (6) tick();

    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
